// File: rtl/csc_wl_cmp_pack.sv
// Compressed-weight packer for the CSC weight-load path. It merges compressed weight
// entries with per-slice masks into low-aligned slices. Optional perf counter: CSC_WL_PACK_PERF_EN.
module csc_wl_cmp_pack #(
  parameter int ATOMC = 8,
  parameter int BPE   = 8,
  parameter int ATOMK = 16
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rstn,
  input  logic                       layer_start,
  input  logic                       cfg_wt_compress_en,
  input  logic [$clog2(ATOMK)-1:0]   cfg_kernel_m1,
  input  logic [15:0]                cfg_group_slices_m1,
  input  logic                       wt_data_pvld,
  output logic                       wt_data_prdy,
  input  logic [ATOMC*BPE-1:0]       wt_data,
  input  logic                       wmb_pvld,
  output logic                       wmb_prdy,
  input  logic [ATOMC-1:0]           wmb_data,
  output logic                       dec_pipe_valid,
  output logic [ATOMC*BPE-1:0]       dec_data,
  output logic [ATOMC-1:0]           dec_mask,
  output logic [9:0]                 dec_mask_en,
  output logic [ATOMK-1:0]           dec_sel,
  output logic [31:0]                dbg_zero_slice_cnt
);

  localparam int DW = ATOMC * BPE;
  localparam int NW = $clog2(ATOMC) + 1;
  localparam int KW = $clog2(ATOMK);
  localparam logic [NW-1:0] ATOMC_N   = NW'(ATOMC);
  localparam logic [9:0]    MASK_EN_C = 10'(256 + (1 << (ATOMC / 8)) - 1);

  logic [NW-1:0]   r_rcnt;
  logic [DW-1:0]   r_res;
  logic [KW-1:0]   r_k;
  logic [15:0]     r_slice;

  logic [NW-1:0]   w_n;
  logic            w_enough;
  logic            w_fire;
  logic            w_wtPrdy;
  logic            w_wmbPrdy;
  logic [2*DW-1:0] w_comb;
  logic [DW-1:0]   w_emit;
  logic [DW-1:0]   w_resNext;
  logic [NW-1:0]   w_rcntNext;
  logic            w_groupEnd;

  always_comb begin
    w_n = '0;
    for (int i = 0; i < ATOMC; i++) begin
      w_n = w_n + NW'(wmb_data[i]);
    end
  end

  assign w_enough = (r_rcnt >= w_n);

  // layer_start blocks any handshake in its cycle
  always_comb begin
    w_fire    = 1'b0;
    w_wtPrdy  = 1'b0;
    w_wmbPrdy = 1'b0;
    if (!layer_start) begin
      if (cfg_wt_compress_en) begin
        w_fire    = wmb_pvld & (w_enough | wt_data_pvld);
        w_wmbPrdy = w_fire;
        w_wtPrdy  = w_fire & ~w_enough;
      end else begin
        w_fire   = wt_data_pvld;
        w_wtPrdy = wt_data_pvld;
      end
    end
  end

  assign wt_data_prdy = w_wtPrdy;
  assign wmb_prdy     = w_wmbPrdy;

  // Residual bytes above rcnt are kept zero, so OR-ing the shifted entry is safe
  assign w_comb = {{DW{1'b0}}, r_res}
                | (w_wtPrdy ? ({{DW{1'b0}}, wt_data} << (int'(r_rcnt) * BPE)) : '0);

  always_comb begin
    w_emit    = '0;
    w_resNext = '0;
    for (int b = 0; b < ATOMC; b++) begin
      w_emit[b*BPE +: BPE]    = (b < int'(w_n)) ? w_comb[b*BPE +: BPE] : '0;
      w_resNext[b*BPE +: BPE] = w_comb[(b + int'(w_n))*BPE +: BPE];
    end
  end

  assign w_rcntNext = w_wtPrdy ? (r_rcnt + ATOMC_N - w_n) : (r_rcnt - w_n);
  assign w_groupEnd = (r_slice == cfg_group_slices_m1);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_rcnt  <= '0;
      r_res   <= '0;
      r_k     <= '0;
      r_slice <= '0;
    end else if (layer_start) begin
      r_rcnt  <= '0;
      r_res   <= '0;
      r_k     <= '0;
      r_slice <= '0;
    end else if (w_fire) begin
      if (w_groupEnd) begin
        r_slice <= '0;
        r_k     <= '0;
      end else begin
        r_slice <= r_slice + 16'd1;
        r_k     <= (r_k == cfg_kernel_m1) ? '0 : r_k + KW'(1);
      end
      if (!cfg_wt_compress_en || w_groupEnd) begin
        r_rcnt <= '0;
        r_res  <= '0;
      end else begin
        r_rcnt <= w_rcntNext;
        r_res  <= w_resNext;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dec_pipe_valid <= 1'b0;
      dec_data       <= '0;
      dec_mask       <= '0;
      dec_mask_en    <= '0;
      dec_sel        <= '0;
    end else begin
      dec_pipe_valid <= w_fire;
      if (w_fire) begin
        dec_data    <= cfg_wt_compress_en ? w_emit : wt_data;
        dec_mask    <= cfg_wt_compress_en ? wmb_data : '1;
        dec_mask_en <= cfg_wt_compress_en ? MASK_EN_C : '0;
        dec_sel     <= {{(ATOMK-1){1'b0}}, 1'b1} << r_k;
      end
    end
  end

`ifdef CSC_WL_PACK_PERF_EN
  logic [31:0] r_zeroCnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_zeroCnt <= '0;
    end else if (layer_start) begin
      r_zeroCnt <= '0;
    end else if (w_fire && cfg_wt_compress_en && (w_n == '0) && (r_zeroCnt != 32'hFFFF_FFFF)) begin
      r_zeroCnt <= r_zeroCnt + 32'd1;
    end
  end

  assign dbg_zero_slice_cnt = r_zeroCnt;
`else
  assign dbg_zero_slice_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_csc_wl_cmp_pack.sv
// Directed-vector bench for csc_wl_cmp_pack with ATOMC=8, BPE=8, ATOMK=16.
// Expectations for dbg_zero_slice_cnt follow CSC_WL_PACK_PERF_EN.
module tb_csc_wl_cmp_pack;

  logic        clk;
  logic        rstn;
  logic        layerStart;
  logic        compressEn;
  logic [3:0]  kernelM1;
  logic [15:0] groupSlicesM1;
  logic        wtPvld;
  logic        wtPrdy;
  logic [63:0] wtData;
  logic        wmbPvld;
  logic        wmbPrdy;
  logic [7:0]  wmbData;
  logic        decValid;
  logic [63:0] decData;
  logic [7:0]  decMask;
  logic [9:0]  decMaskEn;
  logic [15:0] decSel;
  logic [31:0] dbgZero;

  int checks = 0;
  int errors = 0;

  csc_wl_cmp_pack #(.ATOMC(8), .BPE(8), .ATOMK(16)) dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rstn),
    .layer_start         (layerStart),
    .cfg_wt_compress_en  (compressEn),
    .cfg_kernel_m1       (kernelM1),
    .cfg_group_slices_m1 (groupSlicesM1),
    .wt_data_pvld        (wtPvld),
    .wt_data_prdy        (wtPrdy),
    .wt_data             (wtData),
    .wmb_pvld            (wmbPvld),
    .wmb_prdy            (wmbPrdy),
    .wmb_data            (wmbData),
    .dec_pipe_valid      (decValid),
    .dec_data            (decData),
    .dec_mask            (decMask),
    .dec_mask_en         (decMaskEn),
    .dec_sel             (decSel),
    .dbg_zero_slice_cnt  (dbgZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSC_WL_PACK_PERF_EN
  localparam logic [31:0] ZERO_AFTER_ONE = 32'd1;
`else
  localparam logic [31:0] ZERO_AFTER_ONE = 32'd0;
`endif

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge, well away from the sampling rising edge
  task automatic applyStimulus(input logic wtV, input logic [63:0] wt,
                               input logic wmbV, input logic [7:0] wmb, input logic ls);
    wtPvld     = wtV;
    wtData     = wt;
    wmbPvld    = wmbV;
    wmbData    = wmb;
    layerStart = ls;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstn          = 1'b0;
    compressEn    = 1'b1;
    kernelM1      = 4'd3;
    groupSlicesM1 = 16'd15;
    applyStimulus(1'b0, 64'h0, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    checkOutput("rst_valid",  decValid,  1'b0);
    checkOutput("rst_data",   decData,   64'h0);
    checkOutput("rst_sel",    decSel,    16'h0);
    checkOutput("rst_maskEn", decMaskEn, 10'h0);
    checkOutput("rst_dbg",    dbgZero,   32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Compressed: four bytes straight from a fresh entry
    applyStimulus(1'b1, 64'h0807060504030201, 1'b1, 8'h0F, 1'b0);
    #1;
    checkOutput("s1_wtPrdy",  wtPrdy,  1'b1);
    checkOutput("s1_wmbPrdy", wmbPrdy, 1'b1);
    stepCycle();
    checkOutput("s1_valid",  decValid,   1'b1);
    checkOutput("s1_data",   decData,    64'h0000_0000_0403_0201);
    checkOutput("s1_mask",   decMask,    8'h0F);
    checkOutput("s1_maskEn", decMaskEn,  10'h101);
    checkOutput("s1_sel",    decSel,     16'h0001);
    checkOutput("s1_rcnt",   dut.r_rcnt, 4'd4);

    // Served entirely from residual
    applyStimulus(1'b0, 64'h0, 1'b1, 8'h03, 1'b0);
    #1;
    checkOutput("s2_wtPrdy",  wtPrdy,  1'b0);
    checkOutput("s2_wmbPrdy", wmbPrdy, 1'b1);
    stepCycle();
    checkOutput("s2_data", decData,    64'h0605);
    checkOutput("s2_sel",  decSel,     16'h0002);
    checkOutput("s2_rcnt", dut.r_rcnt, 4'd2);

    // Full slice straddling residual and a new entry
    applyStimulus(1'b1, 64'h1817161514131211, 1'b1, 8'hFF, 1'b0);
    #1;
    checkOutput("s3_wtPrdy", wtPrdy, 1'b1);
    stepCycle();
    checkOutput("s3_data", decData,    64'h1615141312110807);
    checkOutput("s3_sel",  decSel,     16'h0004);
    checkOutput("s3_rcnt", dut.r_rcnt, 4'd2);

    // Idle: outputs hold
    applyStimulus(1'b0, 64'h0, 1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("idle_valid", decValid, 1'b0);
    checkOutput("idle_data",  decData,  64'h1615141312110807);

    // Empty slice fires without an entry
    applyStimulus(1'b0, 64'h0, 1'b1, 8'h00, 1'b0);
    #1;
    checkOutput("z_wmbPrdy", wmbPrdy, 1'b1);
    stepCycle();
    checkOutput("z_valid", decValid, 1'b1);
    checkOutput("z_data",  decData,  64'h0);
    checkOutput("z_sel",   decSel,   16'h0008);
    checkOutput("z_dbg",   dbgZero,  ZERO_AFTER_ONE);

    // Not enough residual and no entry: stall
    applyStimulus(1'b0, 64'h0, 1'b1, 8'hFF, 1'b0);
    #1;
    checkOutput("st_wmbPrdy", wmbPrdy, 1'b0);
    checkOutput("st_wtPrdy",  wtPrdy,  1'b0);
    stepCycle();
    checkOutput("st_valid", decValid, 1'b0);

    // Group of two slices drops leftover residual
    groupSlicesM1 = 16'd1;
    applyStimulus(1'b0, 64'h0, 1'b0, 8'h00, 1'b1);
    stepCycle();
    checkOutput("ls_rcnt", dut.r_rcnt, 4'd0);
    checkOutput("ls_dbg",  dbgZero,    32'd0);
    applyStimulus(1'b1, 64'h2827262524232221, 1'b1, 8'h01, 1'b0);
    stepCycle();
    checkOutput("g1_data", decData,    64'h21);
    checkOutput("g1_sel",  decSel,     16'h0001);
    checkOutput("g1_rcnt", dut.r_rcnt, 4'd7);
    applyStimulus(1'b0, 64'h0, 1'b1, 8'h01, 1'b0);
    stepCycle();
    checkOutput("g2_data", decData,    64'h22);
    checkOutput("g2_sel",  decSel,     16'h0002);
    checkOutput("g2_rcnt", dut.r_rcnt, 4'd0);
    applyStimulus(1'b1, 64'h3837363534333231, 1'b1, 8'h03, 1'b0);
    #1;
    checkOutput("g3_wtPrdy", wtPrdy, 1'b1);
    stepCycle();
    checkOutput("g3_data", decData,    64'h3231);
    checkOutput("g3_sel",  decSel,     16'h0001);
    checkOutput("g3_rcnt", dut.r_rcnt, 4'd6);

    // Dense mode, mask stream must be ignored
    groupSlicesM1 = 16'd15;
    compressEn    = 1'b0;
    applyStimulus(1'b0, 64'h0, 1'b0, 8'h00, 1'b1);
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      logic [63:0] entry;
      logic [15:0] expSel;
      entry  = {8{8'(8'h40 + i)}};
      expSel = 16'h0001 << (i % 4);
      applyStimulus(1'b1, entry, 1'b1, 8'h0F, 1'b0);
      #1;
      checkOutput($sformatf("d%0d_wtPrdy", i),  wtPrdy,  1'b1);
      checkOutput($sformatf("d%0d_wmbPrdy", i), wmbPrdy, 1'b0);
      stepCycle();
      checkOutput($sformatf("d%0d_valid", i),  decValid,   1'b1);
      checkOutput($sformatf("d%0d_data", i),   decData,    entry);
      checkOutput($sformatf("d%0d_mask", i),   decMask,    8'hFF);
      checkOutput($sformatf("d%0d_maskEn", i), decMaskEn,  10'h0);
      checkOutput($sformatf("d%0d_sel", i),    decSel,     expSel);
      checkOutput($sformatf("d%0d_rcnt", i),   dut.r_rcnt, 4'd0);
    end

    // layer_start wins over a same-cycle entry
    applyStimulus(1'b1, 64'h5555555555555555, 1'b0, 8'h00, 1'b1);
    #1;
    checkOutput("lsd_wtPrdy", wtPrdy, 1'b0);
    stepCycle();
    checkOutput("lsd_valid", decValid, 1'b0);
    checkOutput("lsd_data",  decData,  64'h4444444444444444);
    applyStimulus(1'b1, 64'h6666666666666666, 1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("post_data", decData, 64'h6666666666666666);
    checkOutput("post_sel",  decSel,  16'h0001);
    applyStimulus(1'b0, 64'h0, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream discards state
    compressEn = 1'b1;
    applyStimulus(1'b1, 64'h7877767574737271, 1'b1, 8'h01, 1'b0);
    stepCycle();
    rstn = 1'b0;
    #1;
    checkOutput("mr_valid", decValid,   1'b0);
    checkOutput("mr_rcnt",  dut.r_rcnt, 4'd0);
    applyStimulus(1'b0, 64'h0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csc_wl_cmp_pack.md
# csc_wl_cmp_pack

Compressed-weight packer for the CSC weight-load path, sitting directly upstream of the weight decoder stage. It merges a dense stream of compressed weight bytes with a per-slice weight-mask (WMB) stream. For each kernel slice it emits exactly the non-zero bytes named by that slice's mask, low-aligned. It drives the decoder's pipe-valid, data, mask, mask-enable and one-hot kernel-select inputs. A residual byte buffer absorbs slices that straddle weight-entry boundaries.

## Interface
- ATOMC, 8, bytes per weight entry / mask bits per slice; multiple of 8, max 64
- BPE, 8, bits per weight element
- ATOMK, 16, kernels per atomic group (width of one-hot select)
- Reset: one clock; reset is asynchronous and active-low.
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  async active-low reset
- layer_start  in  1  sync pulse: clear counters and residual
- cfg_wt_compress_en  in  1  1 = compressed weights, 0 = dense
- cfg_kernel_m1  in  clog2(ATOMK)  kernels per group minus 1
- cfg_group_slices_m1  in  16  slices per weight group minus 1
- wt_data_pvld / wt_data_prdy  in / out  1 / 1  weight-entry handshake
- wt_data  in  ATOMC*BPE  compressed weight entry; byte 0 is consumed first
- wmb_pvld / wmb_prdy  in / out  1 / 1  mask handshake
- wmb_data  in  ATOMC  slice mask; bit i = element i is non-zero
- dec_pipe_valid  out  1  one slice valid this cycle
- dec_data  out  ATOMC*BPE  packed non-zero bytes, low-aligned, upper bytes zero
- dec_mask  out  ATOMC  slice mask
- dec_mask_en  out  10  bits [ATOMC/8-1:0] and bit 8 set when compressed, all zero otherwise
- dec_sel  out  ATOMK  one-hot kernel select
- dbg_zero_slice_cnt  out  32  perf counter (see Configuration)

## Operation
- n = popcount(wmb_data). rcnt = residual byte count, range 0..ATOMC-1.
- Compressed mode:
  - fire = wmb_pvld & (rcnt >= n | wt_data_pvld).
  - wmb_prdy = fire.
  - wt_data_prdy = fire & (rcnt < n).
- rcnt >= n: emit residual bytes [n-1:0], shift the residual down by n, rcnt -= n; no entry is consumed.
- rcnt < n: concatenate {wt_data, residual[rcnt-1:0]}, emit the low n bytes, keep the remaining bytes; rcnt becomes rcnt + ATOMC - n, which is always < ATOMC.
- n = 0: fires on wmb_pvld alone and emits all-zero data.
- Dense mode (cfg_wt_compress_en = 0):
  - wmb_prdy = 0; wmb input is ignored.
  - fire = wt_data_pvld; wt_data_prdy = wt_data_pvld.
  - dec_data = wt_data; dec_mask = all ones; rcnt is unused and held at 0.
- Kernel select:
  - dec_sel = one-hot of kernel counter k.
  - k increments on each fire and wraps to 0 after cfg_kernel_m1.
- Group handling:
  - A slice counter increments on each fire.
  - On the fire where it equals cfg_group_slices_m1, rcnt is cleared (group padding dropped), the slice counter resets and k resets.
- layer_start clears k, the slice counter and rcnt. It has priority over a same-cycle fire, which is ignored; both readies are 0 that cycle.
- The downstream decoder has no backpressure, so every fire produces exactly one dec_pipe_valid.

## Timing
- Readies are combinational from the valids and state.
- All dec_* outputs are registered: a fire in cycle t gives dec_pipe_valid = 1 in t+1 carrying that slice. Latency is 1.
- Throughput: 1 slice per cycle when inputs are available.
- Data outputs hold their value when dec_pipe_valid = 0.
- Reset values:
  - dec_pipe_valid, dec_data, dec_mask, dec_mask_en, dec_sel: 0.
  - rcnt, k, slice counter, dbg_zero_slice_cnt: 0.
- Reset asserted mid-operation discards the residual and any in-flight slice.

## Configuration
- CSC_WL_PACK_PERF_EN defined:
  - dbg_zero_slice_cnt counts compressed-mode fires with n = 0 and saturates at 32'hFFFF_FFFF.
  - It is cleared by reset and by layer_start.
- Not defined: dbg_zero_slice_cnt is tied to 0 and no counter logic exists.

## Test plan
Bench configuration: ATOMC = 8, cfg_kernel_m1 = 3, cfg_group_slices_m1 = 15 unless stated.
- Compressed, rcnt = 0, wmb = 8'h0F, entry bytes 01..08 -> dec_data = 0x0000_0000_0403_0201, dec_sel = 4'b0001, rcnt = 4, wt_data_prdy = 1.
- Follow-on wmb = 8'h03 with wt_data_pvld = 0 -> fires, dec_data low bytes 06,05, wt_data_prdy = 0, rcnt = 2, dec_sel = 4'b0010.
- Follow-on wmb = 8'hFF with entry bytes 11..18 -> dec_data bytes[0..7] = 07,08,11,12,13,14,15,16, rcnt = 2.
- wmb = 8'h00 with wt_data_pvld = 0 -> emits zero data the next cycle; with PERF_EN, dbg_zero_slice_cnt = 1.
- cfg_group_slices_m1 = 1: two slices with masks 8'h01 and 8'h01 -> after the second fire rcnt = 0 (6 bytes dropped) and dec_sel returns to 4'b0001 on the next slice.
- Dense mode, 5 entries back-to-back -> 5 consecutive dec_pipe_valid, dec_mask = 8'hFF, dec_mask_en = 0, dec_sel sequence 1,2,4,8,1. Then layer_start asserted together with wt_data_pvld -> no fire that cycle.
